// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : N-bit universal shift register. Supports hold, logical,
//               arithmetic and rotate shifts in both directions, parallel
//               load and clear. An op runs either as a single step (en) or
//               as a counted burst (start/shamt) with a busy/done handshake.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-high reset
//               mode   - operation select (hold/SHR/SHL/ROR/ROL/SAR/LOAD/CLR)
//               en     - single-step enable, honoured in IDLE only
//               start  - burst request, honoured in IDLE only (beats en)
//               shamt  - number of steps in a burst
//               d      - parallel load data
//               si_r   - serial input entering at MSB on right shifts
//               si_l   - serial input entering at LSB on left shifts
//               q      - register contents
//               so_r   - q[0]   (right-shift serial out)
//               so_l   - q[N-1] (left-shift serial out)
//               busy   - high while a burst is shifting
//               done   - one-cycle pulse at burst completion
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    mode,
  input  logic          en,
  input  logic          start,
  input  logic [CW-1:0] shamt,
  input  logic [N-1:0]  d,
  input  logic          si_r,
  input  logic          si_l,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_SAR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  q_nx;
  logic [CW-1:0] count, count_nx;
  logic [2:0]    mode_l, mode_l_nx;

  // One step of the selected operation applied to the current contents.
  function automatic logic [N-1:0] step_op(
    input logic [2:0]   op,
    input logic [N-1:0] cur,
    input logic [N-1:0] load,
    input logic         sr,
    input logic         sl
  );
    logic [N-1:0] res;
    res = cur;
    case (op)
      MODE_HOLD: res = cur;
      MODE_SHR:  res = {sr, cur[N-1:1]};
      MODE_SHL:  res = {cur[N-2:0], sl};
      MODE_ROR:  res = {cur[0], cur[N-1:1]};
      MODE_ROL:  res = {cur[N-2:0], cur[N-1]};
      MODE_SAR:  res = {cur[N-1], cur[N-1:1]};
      MODE_LOAD: res = load;
      MODE_CLR:  res = '0;
      default:   res = cur;
    endcase
    return res;
  endfunction

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    count_nx  = count;
    mode_l_nx = mode_l;
    case (state)
      IDLE: begin
        if (start) begin
          mode_l_nx = mode;
          // Non-shifting ops complete at the start edge itself; a zero-length
          // shift burst leaves q alone but still reports completion.
          if (mode == MODE_HOLD || mode == MODE_LOAD || mode == MODE_CLR) begin
            q_nx     = step_op(mode, q, d, si_r, si_l);
            state_nx = DONE;
          end else if (shamt == '0) begin
            state_nx = DONE;
          end else begin
            count_nx = shamt;
            state_nx = SHIFT;
          end
        end else if (en) begin
          q_nx = step_op(mode, q, d, si_r, si_l);
        end
      end
      SHIFT: begin
        q_nx     = step_op(mode_l, q, d, si_r, si_l);
        count_nx = count - CW'(1);
        if (count == CW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      count  <= '0;
      mode_l <= MODE_HOLD;
    end else begin
      state  <= state_nx;
      q      <= q_nx;
      count  <= count_nx;
      mode_l <= mode_l_nx;
    end
  end

  assign so_r = q[0];
  assign so_l = q[N-1];
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Self-checking bench for universal_shift_register. Directed
//               scenarios plus randomized single steps and bursts compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    mode;
  logic          en;
  logic          start;
  logic [CW-1:0] shamt;
  logic [N-1:0]  d;
  logic          si_r;
  logic          si_l;
  logic [N-1:0]  q;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  int vectors;
  int fails;
  logic [N-1:0] exp_q;

  universal_shift_register #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .en    (en),
    .start (start),
    .shamt (shamt),
    .d     (d),
    .si_r  (si_r),
    .si_l  (si_l),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference step computed with plain integer arithmetic.
  function automatic logic [N-1:0] model_step(input logic [2:0] m, input logic [N-1:0] v,
                                              input logic sr, input logic sl,
                                              input logic [N-1:0] dd);
    longint x, top, r;
    x   = longint'(v);
    top = longint'(1) << (N - 1);
    case (m)
      3'd1:    r = x / 2 + (sr ? top : 0);
      3'd2:    r = (x * 2 + (sl ? 1 : 0)) % (top * 2);
      3'd3:    r = x / 2 + (x % 2) * top;
      3'd4:    r = (x * 2) % (top * 2) + x / top;
      3'd5:    r = x / 2 + (x / top) * top;
      3'd6:    r = longint'(dd);
      3'd7:    r = 0;
      default: r = x;
    endcase
    return r[N-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode = 3'd0; en = 1'b0; start = 1'b0; shamt = '0; d = '0; si_r = 1'b0; si_l = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (q !== '0) begin $display("FAIL reset_q: got %h want 00", q); fails++; end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done); fails++;
    end
    tick();
    rst = 1'b0;
    tick();
    exp_q = '0;
  endtask

  task automatic test_load_shr();
    mode = 3'b110; d = 8'hA5; en = 1'b1;
    tick();
    vectors++;
    if (q !== 8'hA5 || so_r !== 1'b1 || so_l !== 1'b1) begin
      $display("FAIL load: got q=%h so_r=%b so_l=%b want A5 1 1", q, so_r, so_l); fails++;
    end
    mode = 3'b001; si_r = 1'b1;
    tick();
    vectors++;
    if (q !== 8'hD2 || so_r !== 1'b0) begin
      $display("FAIL shr_step: got q=%h so_r=%b want D2 0", q, so_r); fails++;
    end
    idle_inputs();
    exp_q = 8'hD2;
  endtask

  task automatic test_burst_rol();
    mode = 3'b110; d = 8'hA5; en = 1'b1;
    tick();
    mode = 3'b100; shamt = 4'd3; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL rol_busy[%0d]: got busy=%b done=%b want 1 0", i, busy, done); fails++;
      end
      tick();
    end
    vectors++;
    if (q !== 8'h2D || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL rol_end: got q=%h done=%b busy=%b want 2D 1 0", q, done, busy); fails++;
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h2D) begin
      $display("FAIL rol_idle: got q=%h done=%b busy=%b want 2D 0 0", q, done, busy); fails++;
    end
    idle_inputs();
    exp_q = 8'h2D;
  endtask

  task automatic test_sar_ignore();
    mode = 3'b110; d = 8'h90; en = 1'b1;
    tick();
    mode = 3'b101; shamt = 4'd2; start = 1'b1; en = 1'b0;
    tick();
    // Garbage on the controls while the burst runs.
    for (int i = 0; i < 2; i++) begin
      mode = 3'(i + 6); en = 1'b1; start = 1'b1; d = 8'h3C; shamt = 4'd9;
      tick();
    end
    vectors++;
    if (q !== 8'hE4 || done !== 1'b1) begin
      $display("FAIL sar_burst: got q=%h done=%b want E4 1", q, done); fails++;
    end
    idle_inputs();
    tick();
    exp_q = 8'hE4;
  endtask

  task automatic test_shamt_zero();
    mode = 3'b110; d = 8'h5B; en = 1'b1;
    tick();
    mode = 3'b011; shamt = 4'd0; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    vectors++;
    if (q !== 8'h5B || busy !== 1'b0 || done !== 1'b1) begin
      $display("FAIL shamt0: got q=%h busy=%b done=%b want 5B 0 1", q, busy, done); fails++;
    end
    tick();
    vectors++;
    if (q !== 8'h5B || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL shamt0_after: got q=%h busy=%b done=%b want 5B 0 0", q, busy, done); fails++;
    end
    idle_inputs();
    exp_q = 8'h5B;
  endtask

  task automatic test_shl_serial();
    logic [3:0] pat;
    pat = 4'b1101; // applied LSB first: 1,0,1,1
    mode = 3'b111; en = 1'b1;
    tick();
    mode = 3'b010;
    for (int i = 0; i < 4; i++) begin
      si_l = pat[i];
      tick();
    end
    vectors++;
    if (q !== 8'h0B) begin $display("FAIL shl_serial: got %h want 0B", q); fails++; end
    // start and en together: burst wins, no single step at the start edge.
    si_l = 1'b1; shamt = 4'd2; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    vectors++;
    if (q !== 8'h0B || busy !== 1'b1) begin
      $display("FAIL start_priority: got q=%h busy=%b want 0B 1", q, busy); fails++;
    end
    tick();
    tick();
    vectors++;
    if (q !== 8'h2F || done !== 1'b1) begin
      $display("FAIL priority_burst: got q=%h done=%b want 2F 1", q, done); fails++;
    end
    idle_inputs();
    tick();
    exp_q = 8'h2F;
  endtask

  task automatic test_reset_mid_burst();
    int seen_done;
    mode = 3'b110; d = 8'hFF; en = 1'b1;
    tick();
    mode = 3'b001; shamt = 4'd8; start = 1'b1; en = 1'b0; si_r = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL async_reset: got q=%h busy=%b done=%b want 00 0 0", q, busy, done); fails++;
    end
    #3 rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      $display("FAIL reset_no_done: got %0d busy/done cycles want 0", seen_done); fails++;
    end
    idle_inputs();
    exp_q = '0;
  endtask

  task automatic test_random();
    logic [2:0] m;
    int         n;
    for (int op = 0; op < 60; op++) begin
      m = 3'($urandom_range(0, 7));
      d = N'($urandom);
      si_r = 1'($urandom); si_l = 1'($urandom);
      mode = m;
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, 11);
        shamt = CW'(n); start = 1'b1; en = 1'($urandom);
        tick();
        start = 1'b0;
        if (m == 3'd0 || m == 3'd6 || m == 3'd7) begin
          exp_q = model_step(m, exp_q, si_r, si_l, d);
          n = 0;
        end
        for (int i = 0; i < n; i++) begin
          vectors++;
          if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL rnd_busy op%0d step%0d: got busy=%b done=%b want 1 0", op, i, busy, done); fails++;
          end
          si_r = 1'($urandom); si_l = 1'($urandom);
          mode = 3'($urandom); en = 1'($urandom); start = 1'($urandom); d = N'($urandom);
          exp_q = model_step(m, exp_q, si_r, si_l, 8'h00);
          tick();
        end
        vectors++;
        if (q !== exp_q || done !== 1'b1 || busy !== 1'b0) begin
          $display("FAIL rnd_burst op%0d mode%0d: got q=%h done=%b want q=%h done=1", op, m, q, done, exp_q); fails++;
        end
        start = 1'b0; en = 1'b0;
        tick();
        vectors++;
        if (q !== exp_q || done !== 1'b0) begin
          $display("FAIL rnd_after op%0d: got q=%h done=%b want %h 0", op, q, done, exp_q); fails++;
        end
      end else begin
        en = 1'($urandom); start = 1'b0;
        if (en) exp_q = model_step(m, exp_q, si_r, si_l, d);
        tick();
        vectors++;
        if (q !== exp_q || so_r !== exp_q[0] || so_l !== exp_q[N-1] || busy !== 1'b0 || done !== 1'b0) begin
          $display("FAIL rnd_step op%0d mode%0d en%0b: got q=%h want %h", op, m, en, q, exp_q); fails++;
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    exp_q   = '0;
    test_reset();
    test_load_shr();
    test_burst_rol();
    test_sar_ignore();
    test_shamt_zero();
    test_shl_serial();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
